// File: rtl/seg7_scan_driver.sv
// Drives a 4-digit common-anode seven-segment display from an external digit select,
// with a dead-time blanking interval on every select change and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sel,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    localparam int CW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEAD_CYCLES - 1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [1:0]     sel_q;
    logic [15:0]    disp_q;
    logic [3:0]     dp_q;

    logic [3:0]     cur_digit;
    logic           lead_zero;
    logic [3:0]     drv_an;
    logic [6:0]     drv_seg;
    logic           drv_dp;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_q <= '0;
            dp_q   <= '0;
        end else if (load) begin
            disp_q <= value;
            dp_q   <= dp_in;
        end
    end

    // A digit counts as a leading zero when it and every more significant digit are zero.
    always_comb begin
        cur_digit = 4'h0;
        lead_zero = 1'b0;
        case (sel_q)
            2'd0: begin
                cur_digit = disp_q[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                cur_digit = disp_q[7:4];
                lead_zero = (disp_q[15:4] == 12'h000);
            end
            2'd2: begin
                cur_digit = disp_q[11:8];
                lead_zero = (disp_q[15:8] == 8'h00);
            end
            default: begin
                cur_digit = disp_q[15:12];
                lead_zero = (disp_q[15:12] == 4'h0);
            end
        endcase
    end

    always_comb begin
        drv_an        = 4'b1111;
        drv_an[sel_q] = 1'b0;
        drv_seg       = (blank_lz && lead_zero) ? 7'h7F : hex_to_seg(cur_digit);
        drv_dp        = ~dp_q[sel_q];
    end

    // Any select change forces the display dark and restarts the dead time, whatever the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BLANK;
            cnt   <= '0;
            sel_q <= 2'd0;
            an    <= 4'b1111;
            seg   <= 7'h7F;
            dp    <= 1'b1;
            busy  <= 1'b1;
        end else if (sel != sel_q) begin
            sel_q <= sel;
            state <= BLANK;
            cnt   <= '0;
            an    <= 4'b1111;
            seg   <= 7'h7F;
            dp    <= 1'b1;
            busy  <= 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == CNT_LAST) begin
                        state <= DRIVE;
                        an    <= drv_an;
                        seg   <= drv_seg;
                        dp    <= drv_dp;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        an    <= 4'b1111;
                        seg   <= 7'h7F;
                        dp    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    an    <= drv_an;
                    seg   <= drv_seg;
                    dp    <= drv_dp;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-level reference model queues the expected
// outputs at each rising edge and a negedge monitor pops and compares them.
module tb_seg7_scan_driver;

    localparam int DEAD = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       busy;
    } out_t;

    localparam out_t OFF = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1, busy: 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;
    out_t exp_q[$];

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .reset(reset), .sel(sel), .value(value), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: counts edges since the last select change and drives once DEAD have passed.
    int          m_sel = 0;
    int          m_since = 0;
    int          m_word = 0;
    int          m_dp = 0;

    always @(posedge clk) begin
        out_t e;
        int   digit;
        if (!reset) begin
            m_sel = 0; m_since = 0; m_word = 0; m_dp = 0;
            exp_q.push_back(OFF);
        end else begin
            if (int'(sel) != m_sel) begin
                m_sel = int'(sel);
                m_since = 0;
            end else if (m_since < DEAD) begin
                m_since++;
            end
            if (m_since >= DEAD) begin
                digit = (m_word >> (4 * m_sel)) % 16;
                e.an = 4'b1111;
                e.an[m_sel] = 1'b0;
                if (blank_lz && m_sel > 0 && (m_word >> (4 * m_sel)) == 0)
                    e.seg = 7'h7F;
                else
                    e.seg = hex_tab[digit];
                e.dp = ((m_dp >> m_sel) % 2 == 1) ? 1'b0 : 1'b1;
                e.busy = 1'b0;
            end else begin
                e = OFF;
            end
            exp_q.push_back(e);
            if (load) begin
                m_word = int'(value);
                m_dp = int'(dp_in);
            end
        end
    end

    task automatic check_output(input string name, input out_t got, input out_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got an=%b seg=%h dp=%b busy=%b expected an=%b seg=%h dp=%b busy=%b",
                     name, $time, got.an, got.seg, got.dp, got.busy,
                     want.an, want.seg, want.dp, want.busy);
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard t=%0t got empty queue expected a pending entry", $time);
            end else begin
                e = exp_q.pop_front();
                if (!reset) e = OFF;
                check_output("out", {an, seg, dp, busy}, e);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("[TB] FAIL an_onehot t=%0t got an=%b expected at most one low bit", $time, an);
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] s, input logic [15:0] v, input logic [3:0] d,
                                  input logic l, input logic b, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            sel      = s;
            value    = v;
            dp_in    = d;
            load     = (c == 0) ? l : 1'b0;
            blank_lz = b;
        end
    endtask

    initial begin
        sel = 2'd2;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        apply_stimulus(2'd2, 16'h0000, 4'h0, 1'b0, 1'b0, 10);

        apply_stimulus(2'd0, 16'h12AF, 4'b0100, 1'b1, 1'b0, 10);
        apply_stimulus(2'd1, 16'h12AF, 4'b0100, 1'b0, 1'b0, 10);
        apply_stimulus(2'd2, 16'h12AF, 4'b0100, 1'b0, 1'b0, 10);
        apply_stimulus(2'd3, 16'h12AF, 4'b0100, 1'b0, 1'b0, 10);

        apply_stimulus(2'd0, 16'h12AF, 4'b0100, 1'b0, 1'b0, 8);
        apply_stimulus(2'd1, 16'h12AF, 4'b0100, 1'b0, 1'b0, 2);
        apply_stimulus(2'd2, 16'h12AF, 4'b0100, 1'b0, 1'b0, 8);

        apply_stimulus(2'd3, 16'h0050, 4'h0, 1'b1, 1'b1, 8);
        apply_stimulus(2'd2, 16'h0050, 4'h0, 1'b0, 1'b1, 8);
        apply_stimulus(2'd1, 16'h0050, 4'h0, 1'b0, 1'b1, 8);
        apply_stimulus(2'd0, 16'h0050, 4'h0, 1'b0, 1'b1, 8);
        apply_stimulus(2'd0, 16'h0000, 4'h0, 1'b1, 1'b1, 4);
        apply_stimulus(2'd1, 16'h0000, 4'h0, 1'b0, 1'b1, 8);
        apply_stimulus(2'd0, 16'h0000, 4'h0, 1'b0, 1'b1, 8);

        apply_stimulus(2'd0, 16'h0003, 4'h0, 1'b1, 1'b0, 3);
        apply_stimulus(2'd0, 16'h0008, 4'h0, 1'b1, 1'b0, 3);

        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_output("async_reset", {an, seg, dp, busy}, OFF);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        apply_stimulus(2'd0, 16'h0000, 4'h0, 1'b0, 1'b0, 8);

        for (int i = 0; i < 150; i++) begin
            apply_stimulus(2'($urandom_range(0, 3)),
                           ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255)),
                           4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 1)),
                           $urandom_range(1, 12));
        end

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
